// File: rtl/tof_event_logger_pkg.sv
// Shared event layout for the TOF logger and the register-map block.
// An event word packs {ts, dt, tof} from MSB down to LSB.
package tof_event_logger_pkg;

  localparam int TOF_W       = 32;
  localparam int DT_W        = 32;
  localparam int EVT_TOF_LSB = 0;
  localparam int EVT_DT_LSB  = EVT_TOF_LSB + TOF_W;
  localparam int EVT_TS_LSB  = EVT_DT_LSB + DT_W;

  // dt value reported when no first pulse preceded the capture
  localparam logic [DT_W-1:0] DT_NO_T0 = 32'hFFFF_FFFF;

  function automatic int tof_evt_w(input int ts_w);
    return TOF_W + DT_W + ts_w;
  endfunction

endpackage

// File: rtl/tof_evt_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// The head is refilled from the array at the next read address, bypassing a write into an empty slot.
module tof_evt_fifo #(
  parameter int AW = 4,
  parameter int DW = 76
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] wr_data,
  input  logic          wr,
  input  logic          rd,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   level_reg, level_next;
  logic [DW-1:0] head_reg;
  logic          push, pop;

  assign empty       = (level_reg == '0);
  assign full        = (level_reg == DEPTH_L);
  assign pop         = rd & ~empty;
  assign push        = wr & (~full | pop);
  assign rd_ptr_next = rd_ptr_reg + AW'(pop);
  assign level_next  = level_reg + (AW + 1)'(push) - (AW + 1)'(pop);
  assign rd_data     = head_reg;
  assign level       = level_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push);
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      // the slot written now becomes the head when nothing older remains
      if (push && level_reg == (AW + 1)'(pop)) head_reg <= wr_data;
      else                                     head_reg <= mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/tof_event_logger.sv
// Timestamps detect_pls_0/1 pairs into TOF events queued for readout,
// and stretches each detect_pls_1 rise into a programmable-width trig_out pulse.
module tof_event_logger
  import tof_event_logger_pkg::*;
#(
  parameter int FIFO_AW   = 4,
  parameter int TS_WIDTH  = 32,
  parameter int STRETCH_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 log_enable,
  input  logic                 detect_pls_0,
  input  logic                 detect_pls_1,
  input  logic [31:0]          pulse_tof,
  input  logic [STRETCH_W-1:0] out_width,
  output logic                 trig_out,
  output logic                 evt_valid,
  input  logic                 evt_rd,
  output logic [31:0]          evt_tof,
  output logic [TS_WIDTH-1:0]  evt_ts,
  output logic [31:0]          evt_dt,
  output logic [FIFO_AW:0]     evt_level,
  output logic [15:0]          drop_cnt
);

  localparam int EVT_W = tof_evt_w(TS_WIDTH);

  logic                 d0_q_reg, d1_q_reg;
  logic [TS_WIDTH-1:0]  ts_reg, t0_reg, ts_diff;
  logic                 t0_valid_reg;
  logic [15:0]          drop_cnt_reg;
  logic [STRETCH_W-1:0] stretch_reg;
  logic                 rise0, rise1, capture, drop;
  logic [31:0]          dt;
  logic [EVT_W-1:0]     wr_data, rd_data;
  logic                 fifo_full, fifo_empty;

  assign rise0   = detect_pls_0 & ~d0_q_reg;
  assign rise1   = detect_pls_1 & ~d1_q_reg;
  assign capture = rise1 & log_enable;
  // full implies non-empty, so a pop is accepted whenever evt_rd is high here
  assign drop    = capture & fifo_full & ~evt_rd;

  // difference in timestamp width keeps dt correct across a ts wrap
  assign ts_diff = ts_reg - t0_reg;
  assign dt      = t0_valid_reg ? 32'(ts_diff) : DT_NO_T0;
  assign wr_data = {ts_reg, dt, pulse_tof};

  tof_evt_fifo #(
    .AW (FIFO_AW),
    .DW (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_data (wr_data),
    .wr      (capture),
    .rd      (evt_rd),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (evt_level)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_tof   = rd_data[EVT_TOF_LSB +: TOF_W];
  assign evt_dt    = rd_data[EVT_DT_LSB +: DT_W];
  assign evt_ts    = rd_data[EVT_TS_LSB +: TS_WIDTH];
  assign drop_cnt  = drop_cnt_reg;
  assign trig_out  = (stretch_reg != '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      d0_q_reg     <= 1'b0;
      d1_q_reg     <= 1'b0;
      ts_reg       <= '0;
      t0_reg       <= '0;
      t0_valid_reg <= 1'b0;
      drop_cnt_reg <= '0;
      stretch_reg  <= '0;
    end else begin
      d0_q_reg <= detect_pls_0;
      d1_q_reg <= detect_pls_1;
      ts_reg   <= log_enable ? ts_reg + TS_WIDTH'(1) : '0;

      // a coincident rise0 re-arms after the capture has consumed the old t0
      if (!log_enable) begin
        t0_valid_reg <= 1'b0;
      end else begin
        if (capture) t0_valid_reg <= 1'b0;
        if (rise0) begin
          t0_reg       <= ts_reg;
          t0_valid_reg <= 1'b1;
        end
      end

      if (drop && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;

      if (rise1)                  stretch_reg <= out_width;
      else if (stretch_reg != '0) stretch_reg <= stretch_reg - STRETCH_W'(1);
    end
  end

endmodule

// File: tb/tb_tof_event_logger.sv
// Scoreboard bench for tof_event_logger: expected events are queued at capture
// time and compared against the FWFT head as the FIFO is drained.
module tb_tof_event_logger;

  localparam int AW  = 4;
  localparam int TSW = 12;
  localparam int SW  = 16;

  logic           clk = 1'b0;
  logic           resetn;
  logic           log_enable;
  logic           detect_pls_0;
  logic           detect_pls_1;
  logic [31:0]    pulse_tof;
  logic [SW-1:0]  out_width;
  logic           trig_out;
  logic           evt_valid;
  logic           evt_rd;
  logic [31:0]    evt_tof;
  logic [TSW-1:0] evt_ts;
  logic [31:0]    evt_dt;
  logic [AW:0]    evt_level;
  logic [15:0]    drop_cnt;

  always #4 clk = ~clk;

  tof_event_logger #(
    .FIFO_AW   (AW),
    .TS_WIDTH  (TSW),
    .STRETCH_W (SW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .log_enable   (log_enable),
    .detect_pls_0 (detect_pls_0),
    .detect_pls_1 (detect_pls_1),
    .pulse_tof    (pulse_tof),
    .out_width    (out_width),
    .trig_out     (trig_out),
    .evt_valid    (evt_valid),
    .evt_rd       (evt_rd),
    .evt_tof      (evt_tof),
    .evt_ts       (evt_ts),
    .evt_dt       (evt_dt),
    .evt_level    (evt_level),
    .drop_cnt     (drop_cnt)
  );

  typedef struct {
    logic [31:0]    tof;
    logic [TSW-1:0] ts;
    logic [31:0]    dt;
  } evt_t;

  evt_t           exp_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  logic [TSW-1:0] ts_now   = '0;
  logic [TSW-1:0] m_t0     = '0;
  bit             m_t0_valid = 1'b0;
  int             m_drop   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // one clock; tracks the timestamp the DUT should be showing afterwards
  task automatic tick();
    logic en_s = log_enable;
    logic rn_s = resetn;
    @(posedge clk);
    #1;
    if (!rn_s || !en_s) ts_now = '0;
    else                ts_now = ts_now + 1'b1;
  endtask

  task automatic wait_ts(input logic [TSW-1:0] target);
    int guard = 0;
    while (ts_now != target && guard < 5000) begin
      tick();
      guard++;
    end
    check_val("wait_ts", 64'(ts_now), 64'(target));
  endtask

  task automatic check_head();
    evt_t e;
    check_val("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("evt_tof", 64'(evt_tof), 64'(e.tof));
      check_val("evt_ts",  64'(evt_ts),  64'(e.ts));
      check_val("evt_dt",  64'(evt_dt),  64'(e.dt));
    end
  endtask

  task automatic pulse0();
    if (log_enable) begin
      m_t0       = ts_now;
      m_t0_valid = 1'b1;
    end
    detect_pls_0 = 1'b1;
    tick();
    detect_pls_0 = 1'b0;
    tick();
  endtask

  task automatic pulse1(input logic [31:0] tof, input bit with_pop);
    evt_t           e;
    logic [TSW-1:0] diff;
    bit             was_empty = (exp_q.size() == 0);
    bit             pushed = 1'b0;
    if (with_pop && evt_valid) check_head();
    if (log_enable) begin
      diff   = ts_now - m_t0;
      e.tof  = tof;
      e.ts   = ts_now;
      e.dt   = m_t0_valid ? 32'(diff) : 32'hFFFF_FFFF;
      m_t0_valid = 1'b0;
      if (exp_q.size() < 2 ** AW) begin
        exp_q.push_back(e);
        pushed = 1'b1;
      end else if (m_drop < 16'hFFFF) begin
        m_drop++;
      end
    end
    detect_pls_1 = 1'b1;
    pulse_tof    = tof;
    evt_rd       = with_pop;
    tick();
    detect_pls_1 = 1'b0;
    evt_rd       = 1'b0;
    if (was_empty && pushed) check_val("valid_after_capture", 64'(evt_valid), 64'd1);
    tick();
  endtask

  task automatic drain();
    int guard = 0;
    while (evt_valid && guard < 64) begin
      check_head();
      evt_rd = 1'b1;
      tick();
      evt_rd = 1'b0;
      guard++;
    end
    check_val("drain_valid", 64'(evt_valid), 64'd0);
    check_val("drain_sb_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int highs;
    resetn       = 1'b0;
    log_enable   = 1'b0;
    detect_pls_0 = 1'b0;
    detect_pls_1 = 1'b0;
    pulse_tof    = '0;
    out_width    = '0;
    evt_rd       = 1'b0;
    tick();
    tick();
    check_val("rst_valid", 64'(evt_valid), 64'd0);
    check_val("rst_level", 64'(evt_level), 64'd0);
    check_val("rst_drop",  64'(drop_cnt),  64'd0);
    check_val("rst_trig",  64'(trig_out),  64'd0);
    check_val("rst_tof",   64'(evt_tof),   64'd0);
    check_val("rst_ts",    64'(evt_ts),    64'd0);
    check_val("rst_dt",    64'(evt_dt),    64'd0);
    resetn = 1'b1;
    tick();

    // basic pair: rise0 at ts=100, rise1 at ts=350
    log_enable = 1'b1;
    wait_ts(12'd100);
    pulse0();
    wait_ts(12'd350);
    pulse1(32'h1234_000B, 1'b0);
    drain();

    // rise1 without a preceding rise0, twice
    pulse1(32'h0000_0A01, 1'b0);
    pulse1(32'h0000_0A02, 1'b0);
    drain();

    // t0 near the top of the timestamp range, capture after the wrap
    wait_ts(12'hFF0);
    pulse0();
    wait_ts(12'h010);
    pulse1(32'h0000_0C03, 1'b0);
    drain();

    // coincident rise0 and rise1: capture sees no t0, next capture uses the new one
    detect_pls_0 = 1'b1;
    pulse1(32'h0000_0D01, 1'b0);
    m_t0 = ts_now - 2'd2;
    m_t0_valid = 1'b1;
    detect_pls_0 = 1'b0;
    tick();
    pulse1(32'h0000_0D02, 1'b0);
    drain();

    // pop on an empty FIFO is ignored
    evt_rd = 1'b1;
    tick();
    evt_rd = 1'b0;
    check_val("empty_rd_level", 64'(evt_level), 64'd0);
    check_val("empty_rd_valid", 64'(evt_valid), 64'd0);

    // stretcher with logging disabled: no events, 5 + retrigger 3 later = 8 cycles
    log_enable = 1'b0;
    tick();
    out_width = 16'd5;
    highs = 0;
    for (int i = 0; i < 14; i++) begin
      detect_pls_1 = (i == 0 || i == 3);
      tick();
      if (trig_out) highs++;
      if (i == 7) check_val("trig_last_high", 64'(trig_out), 64'd1);
      if (i == 8) check_val("trig_fall",      64'(trig_out), 64'd0);
    end
    detect_pls_1 = 1'b0;
    check_val("trig_high_cycles", 64'(highs), 64'd8);
    check_val("trig_no_capture",  64'(evt_valid), 64'd0);
    out_width = 16'd0;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      detect_pls_1 = (i == 0);
      tick();
      if (trig_out) highs++;
    end
    detect_pls_1 = 1'b0;
    check_val("trig_width0", 64'(highs), 64'd0);

    // overflow: 17 captures into 16 slots, then capture with pop while full
    log_enable = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) pulse1(32'hA000_0000 + 32'(i), 1'b0);
    check_val("full_level", 64'(evt_level), 64'd16);
    check_val("full_drop",  64'(drop_cnt),  64'(m_drop));
    pulse1(32'hB000_0000, 1'b1);
    check_val("full_pop_level", 64'(evt_level), 64'd16);
    check_val("full_pop_drop",  64'(drop_cnt),  64'(m_drop));
    drain();

    // reset with queued events and an active stretch
    out_width = 16'd4;
    for (int i = 0; i < 3; i++) pulse1(32'hC000_0000 + 32'(i), 1'b0);
    check_val("pre_rst_level", 64'(evt_level), 64'd3);
    check_val("pre_rst_trig",  64'(trig_out),  64'd1);
    resetn = 1'b0;
    tick();
    exp_q.delete();
    m_drop = 0;
    m_t0_valid = 1'b0;
    check_val("mid_rst_valid", 64'(evt_valid), 64'd0);
    check_val("mid_rst_level", 64'(evt_level), 64'd0);
    check_val("mid_rst_drop",  64'(drop_cnt),  64'(m_drop));
    check_val("mid_rst_trig",  64'(trig_out),  64'd0);
    check_val("mid_rst_tof",   64'(evt_tof),   64'd0);
    resetn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
